// File: rtl/core_boot_pkg.sv
// Shared register offsets, response codes and FSM state types for the core boot mailbox.
package core_boot_pkg;

    localparam logic [31:0] TOHOST_OFF  = 32'h0;
    localparam logic [31:0] STATUS_OFF  = 32'h4;
    localparam logic [31:0] CYCLES_OFF  = 32'h8;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
    typedef enum logic [1:0] {HOLD, COUNT, RUN} rst_state_t;

    // Word-granular match: byte offset bits [1:0] are ignored.
    function automatic logic reg_hit(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [31:0] off);
        logic [31:0] a;
        a = base + off;
        return addr[31:2] == a[31:2];
    endfunction

endpackage

// File: rtl/core_rst_seq.sv
// Synchronises DIP[0], sequences the core reset release and counts cycles the core has run.
module core_rst_seq
    import core_boot_pkg::*;
#(
    parameter int RST_HOLD = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dip_async,
    output logic             core_rst,
    output logic [CNT_W-1:0] cycles
);
    localparam int HW = $clog2(RST_HOLD + 1);

    logic [1:0]       sync_q, sync_d;
    rst_state_t       state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             core_rst_q, core_rst_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;

    always_comb begin
        sync_d     = {sync_q[0], dip_async};
        state_d    = state_q;
        hold_d     = hold_q;
        core_rst_d = core_rst_q;
        case (state_q)
            // Level-sensitive: a DIP already high out of reset still starts the count.
            HOLD: begin
                core_rst_d = 1'b1;
                if (sync_q[1]) begin
                    state_d = COUNT;
                    hold_d  = HW'(RST_HOLD - 1);
                end
            end
            COUNT: begin
                if (!sync_q[1]) begin
                    state_d    = HOLD;
                    core_rst_d = 1'b1;
                end else if (hold_q <= HW'(1)) begin
                    state_d    = RUN;
                    hold_d     = '0;
                    core_rst_d = 1'b0;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            RUN: begin
                core_rst_d = 1'b0;
                if (!sync_q[1]) begin
                    state_d    = HOLD;
                    core_rst_d = 1'b1;
                end
            end
            default: begin
                state_d    = HOLD;
                core_rst_d = 1'b1;
            end
        endcase

        // Cleared on the same edge the core re-enters reset; counts only whole running cycles.
        if (core_rst_d)
            cyc_d = '0;
        else if (!core_rst_q && cyc_q != '1)
            cyc_d = cyc_q + CNT_W'(1);
        else
            cyc_d = cyc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            state_q    <= HOLD;
            hold_q     <= '0;
            core_rst_q <= 1'b1;
            cyc_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            hold_q     <= hold_d;
            core_rst_q <= core_rst_d;
            cyc_q      <= cyc_d;
        end
    end

    assign core_rst = core_rst_q;
    assign cycles   = cyc_q;

endmodule

// File: rtl/core_boot_mailbox.sv
// BAR1 AXI4-Lite slave owning the TOHOST mailbox, STATUS/CYCLES readback and core reset release.
module core_boot_mailbox
    import core_boot_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR = 32'h0008_C120,
    parameter int          RST_HOLD    = 16,
    parameter int          CNT_W       = 32
) (
    input  logic        clk_main_a0,
    input  logic        rst_main,
    input  logic [15:0] vdip,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    input  logic        core_tohost_we,
    input  logic [31:0] core_tohost_wdata,
    output logic        core_rst,
    output logic [31:0] tohost_q,
    output logic        core_done
);
    wr_state_t        wr_state_q, wr_state_d;
    rd_state_t        rd_state_q, rd_state_d;
    logic             awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic             aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [31:0]      aw_addr_q, aw_addr_d, w_data_q, w_data_d;
    logic [3:0]       w_strb_q, w_strb_d;
    logic             bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]       bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]      rdata_q, rdata_d, tohost_d;
    logic             core_wrote_q, core_wrote_d, core_done_q, core_done_d;
    logic [CNT_W-1:0] cycles;
    logic [31:0]      status;
    logic             unused_vdip;

    core_rst_seq #(.RST_HOLD(RST_HOLD), .CNT_W(CNT_W)) u_rst_seq (
        .clk       (clk_main_a0),
        .rst       (rst_main),
        .dip_async (vdip[0]),
        .core_rst  (core_rst),
        .cycles    (cycles)
    );

    assign unused_vdip = ^vdip[15:1];
    assign status      = {30'd0, core_wrote_q, ~core_rst};

    always_comb begin
        wr_state_d   = wr_state_q;
        rd_state_d   = rd_state_q;
        aw_held_d    = aw_held_q;
        w_held_d     = w_held_q;
        aw_addr_d    = aw_addr_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        rvalid_d     = rvalid_q;
        rresp_d      = rresp_q;
        rdata_d      = rdata_q;
        tohost_d     = tohost_q;
        core_wrote_d = core_wrote_q;
        core_done_d  = core_tohost_we;

        if (s_awvalid && awready_q) begin
            aw_held_d = 1'b1;
            aw_addr_d = s_awaddr;
        end
        if (s_wvalid && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = s_wdata;
            w_strb_d = s_wstrb;
        end

        case (wr_state_q)
            W_IDLE: if (aw_held_d && w_held_d) begin
                aw_held_d  = 1'b0;
                w_held_d   = 1'b0;
                wr_state_d = W_RESP;
                bvalid_d   = 1'b1;
                bresp_d    = RESP_SLVERR;
                if (reg_hit(aw_addr_d, TOHOST_ADDR, TOHOST_OFF)) begin
                    bresp_d      = RESP_OKAY;
                    core_wrote_d = 1'b0;
                    for (int i = 0; i < 4; i++)
                        if (w_strb_d[i]) tohost_d[8*i +: 8] = w_data_d[8*i +: 8];
                end
            end
            W_RESP: if (s_bready) begin
                wr_state_d = W_IDLE;
                bvalid_d   = 1'b0;
            end
            default: wr_state_d = W_IDLE;
        endcase

        // Applied after the host write so the core wins a same-cycle collision.
        if (core_tohost_we) begin
            tohost_d     = core_tohost_wdata;
            core_wrote_d = 1'b1;
        end

        case (rd_state_q)
            R_IDLE: if (s_arvalid && arready_q) begin
                rd_state_d = R_DATA;
                rvalid_d   = 1'b1;
                rresp_d    = RESP_OKAY;
                if (reg_hit(s_araddr, TOHOST_ADDR, TOHOST_OFF))
                    rdata_d = tohost_q;
                else if (reg_hit(s_araddr, TOHOST_ADDR, STATUS_OFF))
                    rdata_d = status;
                else if (reg_hit(s_araddr, TOHOST_ADDR, CYCLES_OFF))
                    rdata_d = 32'(cycles);
                else begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end
            end
            R_DATA: if (s_rready) begin
                rd_state_d = R_IDLE;
                rvalid_d   = 1'b0;
            end
            default: rd_state_d = R_IDLE;
        endcase

        // Each channel stops accepting once its half of the write is captured.
        awready_d = (wr_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (wr_state_d == W_IDLE) && !w_held_d;
        arready_d = (rd_state_d == R_IDLE);
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            wr_state_q   <= W_IDLE;
            rd_state_q   <= R_IDLE;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            arready_q    <= 1'b0;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b0;
            rresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
            tohost_q     <= '0;
            core_wrote_q <= 1'b0;
            core_done_q  <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            rd_state_q   <= rd_state_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            arready_q    <= arready_d;
            aw_held_q    <= aw_held_d;
            w_held_q     <= w_held_d;
            aw_addr_q    <= aw_addr_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            tohost_q     <= tohost_d;
            core_wrote_q <= core_wrote_d;
            core_done_q  <= core_done_d;
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_arready = arready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;
    assign core_done = core_done_q;

endmodule

// File: tb/tb_core_boot_mailbox.sv
// Directed bench for core_boot_mailbox: host/core mailbox traffic, reset sequencing, error paths.
module tb_core_boot_mailbox;
    import core_boot_pkg::*;

    localparam logic [31:0] BASE = 32'h0008_C120;

    logic        clk_main_a0 = 1'b0;
    logic        rst_main = 1'b1;
    logic [15:0] vdip = '0;
    logic        s_awvalid = 0, s_awready, s_wvalid = 0, s_wready, s_bvalid, s_bready = 0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata;
    logic [3:0]  s_wstrb = '0;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_arvalid = 0, s_arready, s_rvalid, s_rready = 0;
    logic        core_tohost_we = 0, core_rst, core_done;
    logic [31:0] core_tohost_wdata = '0, tohost_q;

    always #5 clk_main_a0 = ~clk_main_a0;

    core_boot_mailbox #(.TOHOST_ADDR(BASE), .RST_HOLD(16), .CNT_W(32)) dut (
        .clk_main_a0(clk_main_a0), .rst_main(rst_main), .vdip(vdip),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .core_tohost_we(core_tohost_we), .core_tohost_wdata(core_tohost_wdata),
        .core_rst(core_rst), .tohost_q(tohost_q), .core_done(core_done)
    );

    typedef struct { logic [31:0] data; logic [1:0] resp; bit chk_data; } rd_exp_t;
    rd_exp_t    rq[$];
    logic [1:0] bq[$];
    int errors = 0, checks = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_main_a0); #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input logic [1:0] exp_resp,
                             input string tag, input int core_at = -1, input logic [31:0] core_data = '0);
        bit aw_pend = 1, w_pend = 1, awh, wh, got = 0;
        logic [1:0] e;
        bq.push_back(exp_resp);
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        for (int c = 0; c < 100 && (aw_pend || w_pend); c++) begin
            s_awvalid         = aw_pend && (c >= aw_dly);
            s_wvalid          = w_pend && (c >= w_dly);
            core_tohost_we    = (c == core_at);
            core_tohost_wdata = core_data;
            @(negedge clk_main_a0);
            awh = s_awvalid && s_awready;
            wh  = s_wvalid && s_wready;
            tick();
            if (awh) aw_pend = 0;
            if (wh)  w_pend = 0;
        end
        s_awvalid = 0; s_wvalid = 0; core_tohost_we = 0;
        check32({tag, " aw/w accepted"}, {30'd0, aw_pend, w_pend}, 32'd0);
        s_bready = 1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk_main_a0);
            if (s_bvalid) begin
                got = 1;
                e = bq.pop_front();
                check32({tag, " bresp"}, {30'd0, s_bresp}, {30'd0, e});
            end
            tick();
        end
        s_bready = 0;
        check32({tag, " bvalid seen"}, 32'(got), 32'd1);
        if (!got) void'(bq.pop_front());
        @(negedge clk_main_a0);
        check32({tag, " single bvalid"}, {31'd0, s_bvalid}, 32'd0);
        tick();
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                            input bit chk, input string tag, output logic [31:0] data, output time hs_t);
        rd_exp_t e;
        bit done = 0, got = 0;
        e.data = exp_data; e.resp = exp_resp; e.chk_data = chk;
        rq.push_back(e);
        data = '0; hs_t = 0;
        s_araddr = addr; s_arvalid = 1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk_main_a0);
            done = s_arready;
            @(posedge clk_main_a0);
            if (done) hs_t = $time;
            #1;
        end
        s_arvalid = 0;
        s_rready = 1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk_main_a0);
            if (s_rvalid) begin
                got = 1;
                e = rq.pop_front();
                data = s_rdata;
                if (e.chk_data) check32({tag, " rdata"}, s_rdata, e.data);
                check32({tag, " rresp"}, {30'd0, s_rresp}, {30'd0, e.resp});
            end
            tick();
        end
        s_rready = 0;
        check32({tag, " rvalid seen"}, 32'(got), 32'd1);
        if (!got) void'(rq.pop_front());
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                      input string tag);
        logic [31:0] unused_d;
        time unused_t;
        axi_read(addr, exp_data, exp_resp, 1'b1, tag, unused_d, unused_t);
    endtask

    task automatic core_write(input logic [31:0] d, input string tag);
        core_tohost_we = 1; core_tohost_wdata = d;
        tick();
        core_tohost_we = 0;
        check32({tag, " done pulse"}, {31'd0, core_done}, 32'd1);
        check32({tag, " tohost"}, tohost_q, d);
        tick();
        check32({tag, " done clear"}, {31'd0, core_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall, rise;
        logic [31:0] c1, c2;
        time t1, t2;

        repeat (3) tick();
        check32("reset core_rst", {31'd0, core_rst}, 32'd1);
        check32("reset tohost", tohost_q, 32'd0);
        check32("reset core_done", {31'd0, core_done}, 32'd0);
        check32("reset valids", {29'd0, s_bvalid, s_rvalid, s_awready}, 32'd0);
        rst_main = 0;
        tick();
        rd(BASE, 32'h0, RESP_OKAY, "rst tohost");
        rd(BASE + 4, 32'h0, RESP_OKAY, "rst status");

        // W leads AW by three cycles, then a single-byte strobe update.
        axi_write(BASE, 32'hDEADBEEF, 4'hF, 3, 0, RESP_OKAY, "w first");
        rd(BASE, 32'hDEADBEEF, RESP_OKAY, "rb deadbeef");
        axi_write(BASE, 32'h0000_0011, 4'b0001, 0, 1, RESP_OKAY, "strb");
        rd(BASE, 32'hDEADBE11, RESP_OKAY, "rb strb");
        check32("tohost port", tohost_q, 32'hDEADBE11);

        // DIP release: 2 sync cycles + RST_HOLD.
        vdip[0] = 1'b1;
        fall = -1;
        for (int k = 1; k <= 40 && fall < 0; k++) begin
            tick();
            if (!core_rst) fall = k;
        end
        check32("release latency", 32'(fall), 32'd18);
        rd(BASE + 4, 32'h1, RESP_OKAY, "status running");
        axi_read(BASE + 8, 32'h0, RESP_OKAY, 1'b0, "cycles a", c1, t1);
        repeat (5) tick();
        axi_read(BASE + 8, 32'h0, RESP_OKAY, 1'b0, "cycles b", c2, t2);
        check32("cycles delta", c2 - c1, 32'((t2 - t1) / 10));

        core_write(32'h0, "core pass");
        rd(BASE, 32'h0, RESP_OKAY, "pass tohost");
        rd(BASE + 4, 32'h3, RESP_OKAY, "pass status");

        axi_write(BASE, 32'hDEADBEEF, 4'hF, 0, 0, RESP_OKAY, "collide", 0, 32'h5);
        rd(BASE, 32'h5, RESP_OKAY, "collide tohost");
        rd(BASE + 4, 32'h3, RESP_OKAY, "collide status");

        axi_write(BASE + 4, 32'hFFFF_FFFF, 4'hF, 1, 0, RESP_SLVERR, "wr status");
        axi_write(32'h0008_C300, 32'h1234_5678, 4'hF, 0, 2, RESP_SLVERR, "wr unmapped");
        rd(BASE + 4, 32'h3, RESP_OKAY, "status unchanged");
        rd(BASE, 32'h5, RESP_OKAY, "tohost unchanged");
        rd(32'h0008_C200, 32'h0, RESP_SLVERR, "rd unmapped");

        vdip[0] = 1'b0;
        rise = -1;
        for (int k = 1; k <= 10 && rise < 0; k++) begin
            tick();
            if (core_rst) rise = k;
        end
        check32("drop latency<=3", 32'(rise > 0 && rise <= 3), 32'd1);
        rd(BASE + 8, 32'h0, RESP_OKAY, "cycles cleared");
        rd(BASE + 4, 32'h2, RESP_OKAY, "status halted");
        axi_write(BASE, 32'h0000_ABCD, 4'hF, 0, 0, RESP_OKAY, "host clears wrote");
        rd(BASE + 4, 32'h0, RESP_OKAY, "status cleared");
        rd(BASE, 32'h0000_ABCD, RESP_OKAY, "abcd");

        // Reset while a read response is waiting on rready.
        s_araddr = BASE; s_arvalid = 1;
        @(negedge clk_main_a0);
        check32("mid ar ready", {31'd0, s_arready}, 32'd1);
        tick();
        s_arvalid = 0;
        @(negedge clk_main_a0);
        check32("mid rvalid", {31'd0, s_rvalid}, 32'd1);
        rst_main = 1;
        tick();
        rst_main = 0;
        check32("mid rst rvalid", {31'd0, s_rvalid}, 32'd0);
        check32("mid rst core_rst", {31'd0, core_rst}, 32'd1);
        check32("mid rst tohost", tohost_q, 32'd0);
        tick();
        rd(BASE + 4, 32'h0, RESP_OKAY, "post rst status");

        // DIP already high across reset release.
        vdip[0] = 1'b1;
        rst_main = 1;
        repeat (2) tick();
        rst_main = 0;
        fall = -1;
        for (int k = 1; k <= 40 && fall < 0; k++) begin
            tick();
            if (!core_rst) fall = k;
        end
        check32("dip high at reset", 32'(fall), 32'd18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
